// File: rtl/kernel_stream_ctrl.sv
// Job and valid-tracking controller for a LAT-deep leaf datapath that freezes on stall.
// Optional stall-cycle counter (port stall_cnt) is built when KERNEL_STREAM_CTRL_PERF_EN is defined.
module kernel_stream_ctrl #(
    parameter int LAT  = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] nitems,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            stall,
    output logic            busy,
    output logic            done
`ifdef KERNEL_STREAM_CTRL_PERF_EN
    ,
    output logic [CNTW-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [LAT-1:0]  vpipe;
    logic [CNTW-1:0] nitems_q;
    logic [CNTW-1:0] issued;
    logic [CNTW-1:0] retired;
    logic            busy_q;
    logic            done_q;
    logic            accept;
    logic            retire;

    // Outputs are forced low while rst is held, even before the first reset edge lands.
    assign out_valid = vpipe[LAT-1] & ~rst;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~rst & (state == RUN) & ~stall & (issued < nitems_q);
    assign busy      = busy_q & ~rst;
    assign done      = done_q & ~rst;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            nitems_q <= '0;
            issued   <= '0;
            retired  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                issued <= issued + CNTW'(1);
            end
            if (retire) begin
                retired <= retired + CNTW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        issued  <= '0;
                        retired <= '0;
                        if (nitems != '0) begin
                            nitems_q <= nitems;
                            state    <= RUN;
                            busy_q   <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    if (issued == nitems_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retired == nitems_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid shadow of the datapath: frozen with it on stall, one bit per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else if (!stall) begin
            vpipe[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

`ifdef KERNEL_STREAM_CTRL_PERF_EN
    logic [CNTW-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt_q <= '0;
        end else if (busy_q && stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Randomized and directed bench for kernel_stream_ctrl; runs a LAT=1 and a LAT=3 instance
// side by side on shared stimulus, each against its own item-queue reference model.
module tb_kernel_stream_ctrl;

    localparam int CW       = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;
    localparam int QD       = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] nitems;
    logic          in_valid;
    logic          out_ready;
    logic [1:0]    ir, ov, st, bz, dn;
`ifdef KERNEL_STREAM_CTRL_PERF_EN
    logic [CW-1:0] sc [2];
    int            sc_done [2];
`endif

    always #5 clk = ~clk;

    kernel_stream_ctrl #(.LAT(1), .CNTW(CW)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start), .nitems(nitems),
        .in_valid(in_valid), .in_ready(ir[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .stall(st[0]), .busy(bz[0]), .done(dn[0])
`ifdef KERNEL_STREAM_CTRL_PERF_EN
        , .stall_cnt(sc[0])
`endif
    );

    kernel_stream_ctrl #(.LAT(3), .CNTW(CW)) u_dut_l3 (
        .clk(clk), .rst(rst), .start(start), .nitems(nitems),
        .in_valid(in_valid), .in_ready(ir[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .stall(st[1]), .busy(bz[1]), .done(dn[1])
`ifdef KERNEL_STREAM_CTRL_PERF_EN
        , .stall_cnt(sc[1])
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: job phase, counters and an ordered queue of in-flight items, each
    // tagged with the advance count at which it entered the datapath.
    int m_phase [2], m_n [2], m_iss [2], m_ret [2], m_adv [2], m_scnt [2];
    int m_qh [2], m_qc [2];
    int m_tag [2][QD];

    int acc_cnt [2], ret_cnt [2], done_cnt [2], stall_cyc [2], busy_cyc [2], ir_cyc [2];
    int first_acc [2], done_cyc [2];
    int start_cyc;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear(int k);
        m_phase[k] = PH_IDLE;
        m_n[k] = 0; m_iss[k] = 0; m_ret[k] = 0;
        m_adv[k] = 0; m_scnt[k] = 0; m_qh[k] = 0; m_qc[k] = 0;
    endtask

    task automatic obs_clear();
        for (int k = 0; k < 2; k++) begin
            acc_cnt[k] = 0; ret_cnt[k] = 0; done_cnt[k] = 0; stall_cyc[k] = 0;
            busy_cyc[k] = 0; ir_cyc[k] = 0; first_acc[k] = -1; done_cyc[k] = -1;
`ifdef KERNEL_STREAM_CTRL_PERF_EN
            sc_done[k] = -1;
`endif
        end
        start_cyc = cyc;
    endtask

    // Compare one cycle at negedge+1, then advance the models across the next rising edge.
    task automatic step();
        bit e_ov, e_st, e_ir, e_bz, e_dn, acc, rt;
        int l;
        #1;
        for (int k = 0; k < 2; k++) begin
            l    = lat_of(k);
            e_ov = !rst && (m_qc[k] > 0) && (m_adv[k] - m_tag[k][m_qh[k]] == l - 1);
            e_st = e_ov && !out_ready;
            e_ir = !rst && (m_phase[k] == PH_RUN) && !e_st && (m_iss[k] < m_n[k]);
            e_bz = !rst && ((m_phase[k] == PH_RUN) || (m_phase[k] == PH_DRAIN));
            e_dn = !rst && (m_phase[k] == PH_DONE);
            chk($sformatf("lat%0d in_ready c%0d", l, cyc), int'(ir[k]), int'(e_ir));
            chk($sformatf("lat%0d out_valid c%0d", l, cyc), int'(ov[k]), int'(e_ov));
            chk($sformatf("lat%0d stall c%0d", l, cyc), int'(st[k]), int'(e_st));
            chk($sformatf("lat%0d busy c%0d", l, cyc), int'(bz[k]), int'(e_bz));
            chk($sformatf("lat%0d done c%0d", l, cyc), int'(dn[k]), int'(e_dn));
`ifdef KERNEL_STREAM_CTRL_PERF_EN
            if (!rst) chk($sformatf("lat%0d stall_cnt c%0d", l, cyc), int'(sc[k]), m_scnt[k]);
            if (dn[k]) sc_done[k] = int'(sc[k]);
`endif
            if (in_valid && ir[k]) begin
                acc_cnt[k]++;
                if (first_acc[k] < 0) first_acc[k] = cyc;
            end
            if (ov[k] && out_ready) ret_cnt[k]++;
            if (st[k]) stall_cyc[k]++;
            if (bz[k]) busy_cyc[k]++;
            if (ir[k]) ir_cyc[k]++;
            if (dn[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end

            acc = in_valid && e_ir;
            rt  = e_ov && out_ready;
            if (rst) begin
                model_clear(k);
            end else begin
                if (e_bz && e_st && (m_scnt[k] < (1 << CW) - 1)) m_scnt[k]++;
                case (m_phase[k])
                    PH_IDLE: if (start) begin
                        m_scnt[k] = 0;
                        if (nitems != 0) begin
                            m_n[k] = int'(nitems); m_iss[k] = 0; m_ret[k] = 0;
                            m_phase[k] = PH_RUN;
                        end else begin
                            m_phase[k] = PH_DONE;
                        end
                    end
                    PH_RUN:   if (m_iss[k] == m_n[k]) m_phase[k] = PH_DRAIN;
                    PH_DRAIN: if (m_ret[k] == m_n[k]) m_phase[k] = PH_DONE;
                    default:  m_phase[k] = PH_IDLE;
                endcase
                if (rt) begin
                    m_qh[k] = (m_qh[k] + 1) % QD;
                    m_qc[k]--;
                end
                if (!e_st) m_adv[k]++;
                if (acc) begin
                    m_tag[k][(m_qh[k] + m_qc[k]) % QD] = m_adv[k];
                    m_qc[k]++;
                end
                m_iss[k] += int'(acc);
                m_ret[k] += int'(rt);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic begin_job(int n);
        obs_clear();
        start  = 1'b1;
        nitems = CW'(n);
        step();
        start  = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int c;
        c = 0;
        while (!((m_phase[0] == PH_IDLE) && (m_phase[1] == PH_IDLE)) && (c < budget)) begin
            step();
            c++;
        end
        chk("wait_idle within budget", int'(c < budget), 1);
    endtask

    task automatic job_checks(string name, int n, int exp_done);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s lat%0d accepts", name, lat_of(k)), acc_cnt[k], n);
            chk($sformatf("%s lat%0d retires", name, lat_of(k)), ret_cnt[k], n);
            chk($sformatf("%s lat%0d done pulses", name, lat_of(k)), done_cnt[k], exp_done);
        end
    endtask

    initial begin
        int n, c;
        logic [5:0] pat;

        rst = 1'b1; start = 1'b0; nitems = '0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) model_clear(k);
        obs_clear();
        @(negedge clk);
        in_valid = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Full throughput, first start taken right after reset release
        in_valid = 1'b1; out_ready = 1'b1;
        begin_job(4);
        wait_idle(60);
        job_checks("full4", 4, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("full4 lat%0d stall cycles", lat_of(k)), stall_cyc[k], 0);
            chk($sformatf("full4 lat%0d done latency", lat_of(k)), done_cyc[k] - first_acc[k], 4 + lat_of(k) + 1);
        end

        // Backpressure window 4..7 after the first accept
        begin_job(5);
        for (int j = 0; j < 12; j++) begin
            out_ready = !((j >= 4) && (j <= 7));
            step();
        end
        out_ready = 1'b1;
        wait_idle(60);
        job_checks("bp5", 5, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bp5 lat%0d stall cycles", lat_of(k)), stall_cyc[k], 4);
`ifdef KERNEL_STREAM_CTRL_PERF_EN
            chk($sformatf("bp5 lat%0d stall_cnt at done", lat_of(k)), sc_done[k], 4);
`endif
        end

        // Empty job
        in_valid = 1'b1;
        begin_job(0);
        wait_idle(10);
        job_checks("empty", 0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("empty lat%0d done cycle", lat_of(k)), done_cyc[k] - start_cyc, 1);
            chk($sformatf("empty lat%0d busy cycles", lat_of(k)), busy_cyc[k], 0);
            chk($sformatf("empty lat%0d in_ready cycles", lat_of(k)), ir_cyc[k], 0);
`ifdef KERNEL_STREAM_CTRL_PERF_EN
            chk($sformatf("empty lat%0d stall_cnt cleared", lat_of(k)), sc_done[k], 0);
`endif
        end

        // Ignored start while running, then reset with items still in flight
        in_valid = 1'b1; out_ready = 1'b0;
        begin_job(2);
        for (int j = 0; j < 6; j++) begin
            start  = (j == 1);
            nitems = CW'(9);
            step();
        end
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort lat%0d done pulses", lat_of(k)), done_cnt[k], 0);
            chk($sformatf("abort lat%0d accepts", lat_of(k)), acc_cnt[k], (k == 0) ? 1 : 2);
        end

        // Sparse input, started in the first cycle after reset
        in_valid = 1'b0; out_ready = 1'b1;
        begin_job(3);
        pat = 6'b101001;
        for (int j = 0; j < 6; j++) begin
            in_valid = pat[j];
            step();
        end
        in_valid = 1'b0;
        wait_idle(40);
        job_checks("sparse3", 3, 1);

        // Largest job the counters can express
        in_valid = 1'b1; out_ready = 1'b1;
        begin_job(15);
        wait_idle(80);
        job_checks("max15", 15, 1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("max15 lat%0d done latency", lat_of(k)), done_cyc[k] - first_acc[k], 15 + lat_of(k) + 1);

        // Long stall drives the performance counter into saturation
        in_valid = 1'b1; out_ready = 1'b0;
        begin_job(1);
        repeat (20) step();
        out_ready = 1'b1;
        wait_idle(40);
        job_checks("sat1", 1, 1);
`ifdef KERNEL_STREAM_CTRL_PERF_EN
        for (int k = 0; k < 2; k++)
            chk($sformatf("sat1 lat%0d stall_cnt saturated", lat_of(k)), sc_done[k], (1 << CW) - 1);
`endif

        // Random jobs with random handshakes and stray starts
        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(0, 15));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            begin_job(n);
            c = 0;
            while (!((m_phase[0] == PH_IDLE) && (m_phase[1] == PH_IDLE)) && (c < 400)) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                start     = (m_phase[0] != PH_IDLE) && (m_phase[1] != PH_IDLE) && ($urandom_range(0, 7) == 0);
                nitems    = CW'($urandom_range(0, 15));
                step();
                c++;
            end
            start = 1'b0;
            chk($sformatf("rand%0d within budget", r), int'(c < 400), 1);
            job_checks($sformatf("rand%0d", r), n, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
